// File: rtl/c2f_consumer_pkg.sv
// rtl/c2f_consumer_pkg.sv - shared types and sizes for the C2F consumer
//
// Purpose: scalar typedefs, C2F ring geometry and the consumer FSM encoding.
// Ports: none (package).
package c2f_consumer_pkg;

    typedef logic [31:0] uint32;
    typedef logic [63:0] uint64;
    typedef logic [7:0]  ByteMask64;

    localparam int C2F_CHUNKSIZE  = 128;
    localparam int C2F_SIZE_NBITS = 12;
    localparam int C2F_NQWORDS    = C2F_CHUNKSIZE / 8;
    localparam int C2F_OFFSET_W   = $clog2(C2F_NQWORDS);
    localparam int C2F_INDEX_W    = C2F_SIZE_NBITS - 3 - C2F_OFFSET_W;

    typedef logic [C2F_INDEX_W-1:0]  C2FChunkIndex;
    typedef logic [C2F_OFFSET_W-1:0] C2FChunkOffset;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DELAY,
        ST_ACK
    } c2f_state_t;

endpackage

// File: rtl/c2f_consumer.sv
// rtl/c2f_consumer.sv - drains C2F chunks into a running 64-bit checksum
//
// Purpose: whenever wrIndex != rdIndex, reads every qword of the chunk at
// rdIndex from the synchronous-read C2F RAM, adds it into csData, waits
// countInit throttle cycles and pulses dtAck so the parent advances rdIndex.
// Ports:
//   sysClk, sysRst_n : clock, asynchronous active-low reset
//   wrIndex, rdIndex : producer / consumer chunk pointers
//   dtAck            : one-cycle pulse, chunk at rdIndex consumed
//   rdOffset, rdData : RAM read address (qword in chunk) and data (1-cycle latency)
//   csData, csValid  : running checksum and "idle with nothing pending"
//   csReset          : synchronous checksum clear
//   countInit        : throttle cycles inserted per chunk
module c2f_consumer
    import c2f_consumer_pkg::*;
(
    input  logic          sysClk,
    input  logic          sysRst_n,
    input  C2FChunkIndex  wrIndex,
    input  C2FChunkIndex  rdIndex,
    output logic          dtAck,
    output C2FChunkOffset rdOffset,
    input  uint64         rdData,
    output uint64         csData,
    output logic          csValid,
    input  logic          csReset,
    input  uint32         countInit
);

    localparam C2FChunkOffset LAST_OFFSET = C2FChunkOffset'(C2F_NQWORDS - 1);

    c2f_state_t    state;
    c2f_state_t    state_nxt;
    C2FChunkOffset offset;
    logic          rd_valid;
    uint32         count;

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (wrIndex != rdIndex) state_nxt = ST_READ;
            ST_READ:  if (offset == LAST_OFFSET) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = (countInit == 32'd0) ? ST_ACK : ST_DELAY;
            // Counter holds the number of DELAY cycles still owed, this one included.
            ST_DELAY: if (count == 32'd1) state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            offset   <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
            csData   <= '0;
        end else begin
            // Offset walks 0..N-1 in READ and parks at 0 everywhere else.
            if (state == ST_READ && offset != LAST_OFFSET) begin
                offset <= offset + 1'b1;
            end else begin
                offset <= '0;
            end

            // A read issued this cycle returns data on the next one.
            rd_valid <= (state == ST_READ);

            if (state == ST_DRAIN) begin
                count <= countInit;
            end else if (state == ST_DELAY) begin
                count <= count - 32'd1;
            end

            // Clear wins over a coinciding accumulate; that qword is lost.
            if (csReset) begin
                csData <= '0;
            end else if (rd_valid) begin
                csData <= csData + rdData;
            end
        end
    end

    assign rdOffset = offset;
    assign dtAck    = (state == ST_ACK);
    assign csValid  = (state == ST_IDLE) && (wrIndex == rdIndex);

endmodule

// File: tb/tb_c2f_consumer.sv
// tb/tb_c2f_consumer.sv - self-checking bench for c2f_consumer
module tb_c2f_consumer;
    import c2f_consumer_pkg::*;

    localparam int N = C2F_NQWORDS;

    logic          sysClk;
    logic          sysRst_n;
    C2FChunkIndex  wrIndex;
    C2FChunkIndex  rdIndex;
    logic          dtAck;
    C2FChunkOffset rdOffset;
    uint64         rdData;
    uint64         csData;
    logic          csValid;
    logic          csReset;
    uint32         countInit;

    logic          ptr_load;
    C2FChunkIndex  ptr_load_val;
    logic          wr_adv;
    C2FChunkIndex  wr_adv_n;

    logic [63:0]   mem [0:(1<<(C2F_SIZE_NBITS-3))-1];

    int            n_checks;
    int            n_fail;
    int            cyc;
    int            ack_times[$];
    logic [63:0]   exp_sum;
    C2FChunkIndex  exp_rd;

    c2f_consumer dut (
        .sysClk    (sysClk),
        .sysRst_n  (sysRst_n),
        .wrIndex   (wrIndex),
        .rdIndex   (rdIndex),
        .dtAck     (dtAck),
        .rdOffset  (rdOffset),
        .rdData    (rdData),
        .csData    (csData),
        .csValid   (csValid),
        .csReset   (csReset),
        .countInit (countInit)
    );

    always #5 sysClk = ~sysClk;

    // Synchronous-read RAM and the parent's pointer registers.
    always @(posedge sysClk) begin
        rdData <= mem[{rdIndex, rdOffset}];
        if (ptr_load) begin
            rdIndex <= ptr_load_val;
            wrIndex <= ptr_load_val;
        end else begin
            if (dtAck) rdIndex <= rdIndex + 1'b1;
            if (wr_adv) wrIndex <= wrIndex + wr_adv_n;
        end
    end

    always @(negedge sysClk) begin
        cyc = cyc + 1;
        if (dtAck === 1'b1) ack_times.push_back(cyc);
    end

    task automatic write_chunk(input C2FChunkIndex idx, input bit ones, output logic [63:0] s);
        logic [63:0] q;
        s = '0;
        for (int i = 0; i < N; i++) begin
            q = ones ? 64'd1 : {$urandom, $urandom};
            mem[{idx, C2FChunkOffset'(i)}] = q;
            s = s + q;
        end
    endtask

    task automatic advance_wr(input int n);
        wr_adv_n = C2FChunkIndex'(n);
        wr_adv   = 1'b1;
        @(posedge sysClk);
        #1 wr_adv = 1'b0;
    endtask

    // Writes n chunks, publishes them at once and waits (bounded) for n acks.
    task automatic run_batch(input int n, input int ci, input bit ones,
                             output int base, output int acks, output logic [63:0] bsum);
        logic [63:0] s;
        base = ack_times.size();
        bsum = '0;
        for (int k = 0; k < n; k++) begin
            write_chunk(wrIndex + C2FChunkIndex'(k), ones, s);
            bsum = bsum + s;
        end
        countInit = ci;
        @(posedge sysClk);
        #1;
        advance_wr(n);
        for (int c = 0; c < n * (N + ci + 3) + 20 && ack_times.size() - base < n; c++)
            @(negedge sysClk);
        repeat (3) @(negedge sysClk);
        acks = ack_times.size() - base;
    endtask

    task automatic test_reset;
        @(negedge sysClk);
        n_checks++;
        if (dtAck !== 1'b0 || rdOffset !== '0 || csData !== 64'd0 || csValid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: dtAck=%b rdOffset=%0d csData=%h csValid=%b, required 0/0/0/1",
                     dtAck, rdOffset, csData, csValid);
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysClk);
            n_checks++;
            if (dtAck !== 1'b0 || rdOffset !== '0 || csValid !== 1'b1 || csData !== 64'd0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: dtAck=%b rdOffset=%0d csValid=%b csData=%h, required 0/0/1/0",
                         i, dtAck, rdOffset, csValid, csData);
            end
        end
    endtask

    task automatic test_one_chunk;
        logic [63:0] s;
        write_chunk(wrIndex, 1'b0, s);
        countInit = 0;
        @(posedge sysClk);
        #1;
        advance_wr(1);
        exp_sum = exp_sum + s;
        exp_rd  = exp_rd + 1'b1;
        @(posedge sysClk);
        for (int k = 0; k < N; k++) begin
            @(negedge sysClk);
            n_checks++;
            if (rdOffset !== C2FChunkOffset'(k) || dtAck !== 1'b0) begin
                n_fail++;
                $display("FAIL one_offset%0d: rdOffset=%0d dtAck=%b, required %0d/0", k, rdOffset, dtAck, k);
            end
        end
        @(negedge sysClk);
        n_checks++;
        if (dtAck !== 1'b0 || rdOffset !== '0) begin
            n_fail++;
            $display("FAIL one_drain: dtAck=%b rdOffset=%0d, required 0/0", dtAck, rdOffset);
        end
        @(negedge sysClk);
        n_checks++;
        if (dtAck !== 1'b1) begin
            n_fail++;
            $display("FAIL one_ack_latency: dtAck=%b, required 1", dtAck);
        end
        @(negedge sysClk);
        n_checks++;
        if (dtAck !== 1'b0 || rdIndex !== exp_rd || csData !== exp_sum || csValid !== 1'b1) begin
            n_fail++;
            $display("FAIL one_result: dtAck=%b rdIndex=%0d csData=%h csValid=%b, required 0/%0d/%h/1",
                     dtAck, rdIndex, csData, csValid, exp_rd, exp_sum);
        end
    endtask

    task automatic test_batch(input string name, input int n, input int ci, input bit ones);
        int base, acks;
        logic [63:0] bsum;
        run_batch(n, ci, ones, base, acks, bsum);
        exp_sum = exp_sum + bsum;
        exp_rd  = exp_rd + C2FChunkIndex'(n);
        n_checks++;
        if (acks != n) begin
            n_fail++;
            $display("FAIL %s_acks: saw %0d, required %0d", name, acks, n);
        end
        for (int k = 1; k < n && k < acks; k++) begin
            n_checks++;
            if (ack_times[base+k] - ack_times[base+k-1] != N + ci + 3) begin
                n_fail++;
                $display("FAIL %s_spacing%0d: %0d cycles, required %0d", name, k,
                         ack_times[base+k] - ack_times[base+k-1], N + ci + 3);
            end
        end
        n_checks++;
        if (rdIndex !== exp_rd || csData !== exp_sum || csValid !== 1'b1 || dtAck !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result: rdIndex=%0d csData=%h csValid=%b dtAck=%b, required %0d/%h/1/0",
                     name, rdIndex, csData, csValid, dtAck, exp_rd, exp_sum);
        end
    endtask

    task automatic test_eight_chunks;
        test_batch("eight", 8, 128, 1'b0);
    endtask

    task automatic test_csreset;
        @(posedge sysClk);
        #1 csReset = 1'b1;
        @(posedge sysClk);
        #1 csReset = 1'b0;
        exp_sum = '0;
        n_checks++;
        if (csData !== 64'd0 || csValid !== 1'b1) begin
            n_fail++;
            $display("FAIL csreset_clear: csData=%h csValid=%b, required 0/1", csData, csValid);
        end
        test_batch("ones", 1, 0, 1'b1);
        n_checks++;
        if (csData !== 64'd16) begin
            n_fail++;
            $display("FAIL ones_sum: csData=%0d, required 16", csData);
        end
    endtask

    task automatic test_wrap;
        C2FChunkIndex max_idx;
        max_idx = '1;
        @(posedge sysClk);
        #1;
        ptr_load_val = max_idx;
        ptr_load     = 1'b1;
        @(posedge sysClk);
        #1 ptr_load = 1'b0;
        exp_rd = max_idx;
        test_batch("wrap", 1, 2, 1'b0);
        n_checks++;
        if (rdIndex !== '0 || wrIndex !== '0) begin
            n_fail++;
            $display("FAIL wrap_index: rdIndex=%0d wrIndex=%0d, required 0/0", rdIndex, wrIndex);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] s;
        bit seen;
        write_chunk(wrIndex, 1'b0, s);
        countInit = 1;
        @(posedge sysClk);
        #1;
        advance_wr(1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge sysClk);
            if (rdOffset === C2FChunkOffset'(5)) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rstmid_reach_read: rdOffset=%0d, required to reach 5", rdOffset);
        end
        sysRst_n = 1'b0;
        #1;
        n_checks++;
        if (dtAck !== 1'b0 || csData !== 64'd0 || rdOffset !== '0 || csValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_state: dtAck=%b csData=%h rdOffset=%0d csValid=%b, required 0/0/0/0",
                     dtAck, csData, rdOffset, csValid);
        end
        @(negedge sysClk);
        sysRst_n = 1'b1;
        exp_sum = s;
        exp_rd  = exp_rd + 1'b1;
        @(posedge sysClk);
        for (int k = 0; k < N; k++) begin
            @(negedge sysClk);
            n_checks++;
            if (rdOffset !== C2FChunkOffset'(k)) begin
                n_fail++;
                $display("FAIL rstmid_reread%0d: rdOffset=%0d, required %0d", k, rdOffset, k);
            end
        end
        repeat (5) @(negedge sysClk);
        n_checks++;
        if (rdIndex !== exp_rd || csData !== exp_sum || csValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_result: rdIndex=%0d csData=%h csValid=%b, required %0d/%h/1",
                     rdIndex, csData, csValid, exp_rd, exp_sum);
        end
    endtask

    task automatic test_random;
        for (int b = 0; b < 3; b++) begin
            test_batch("rand", $urandom_range(1, 4), $urandom_range(0, 9), 1'b0);
        end
    endtask

    initial begin
        sysClk       = 1'b0;
        sysRst_n     = 1'b0;
        csReset      = 1'b0;
        countInit    = '0;
        ptr_load     = 1'b1;
        ptr_load_val = '0;
        wr_adv       = 1'b0;
        wr_adv_n     = '0;
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        exp_sum      = '0;
        exp_rd       = '0;
        for (int i = 0; i < (1 << (C2F_SIZE_NBITS - 3)); i++) mem[i] = '0;
        repeat (3) @(posedge sysClk);
        #1 ptr_load = 1'b0;
        @(negedge sysClk);
        sysRst_n = 1'b1;

        test_reset();
        test_idle();
        test_one_chunk();
        test_eight_chunks();
        test_csreset();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
